// File: rtl/mesi_pkg.sv
// mesi_pkg: shared MESI state, request-op and controller-state encodings.
// Revision: 1.0
`default_nettype none

package mesi_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_state_t;

  typedef enum logic [1:0] {
    OP_RSVD  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_EVICT = 2'b11
  } req_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOOKUP    = 2'b01,
    ST_WRITEBACK = 2'b10,
    ST_RESP      = 2'b11
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with one-hot grant and registered priority pointer.
// Revision: 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // The pointer moves past the winner as soon as the grant is taken; the
  // winner is latched by the caller, so this is equivalent to moving it later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mesi_snoop_ctrl.sv
// mesi_snoop_ctrl: serialised MESI directory controller with snoop invalidation and write-back.
// Revision: 1.0
`default_nettype none

module mesi_snoop_ctrl
  import mesi_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  parameter  int NUM_LINES = 16,
  localparam int LINE_W    = $clog2(NUM_LINES),
  localparam int CORE_W    = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [2*NUM_CORES-1:0]      req_op,
  input  logic [LINE_W*NUM_CORES-1:0] req_line,
  output logic [NUM_CORES-1:0]        req_ready,
  output logic [1:0]                  resp_state,
  output logic [NUM_CORES-1:0]        snoop_inv,
  output logic [LINE_W-1:0]           snoop_line,
  output logic                        wb_valid,
  output logic [CORE_W-1:0]           wb_core,
  input  logic                        wb_ready,
  input  logic [CORE_W-1:0]           dbg_core,
  input  logic [LINE_W-1:0]           dbg_line,
  output logic [1:0]                  dbg_state
);

  ctrl_state_t state, state_n;
  mesi_state_t dir [NUM_CORES][NUM_LINES];
  mesi_state_t col_cur  [NUM_CORES];
  mesi_state_t col_next [NUM_CORES];
  mesi_state_t req_st;

  logic [NUM_CORES-1:0] grant, remote_v, inv_n, snoop_inv_q;
  logic [CORE_W-1:0]    core_q, owner_q, owner_n, core_sel, m_owner;
  logic [LINE_W-1:0]    line_q, line_sel;
  logic [1:0]           op_sel;
  req_op_t              op_q;
  logic                 col_we, remote_m;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (state == ST_IDLE),
    .grant   (grant)
  );

  always_comb begin
    core_sel = '0;
    line_sel = '0;
    op_sel   = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (grant[c]) begin
        core_sel = CORE_W'(c);
        line_sel = req_line[c*LINE_W +: LINE_W];
        op_sel   = req_op[c*2 +: 2];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) col_cur[c] = dir[c][line_q];
  end

  always_comb begin
    state_n  = state;
    col_next = col_cur;
    col_we   = 1'b0;
    inv_n    = '0;
    owner_n  = owner_q;
    remote_v = '0;
    remote_m = 1'b0;
    m_owner  = '0;
    req_st   = col_cur[core_q];
    for (int c = 0; c < NUM_CORES; c++) begin
      if (CORE_W'(c) != core_q) begin
        remote_v[c] = (col_cur[c] != MESI_I);
        if (col_cur[c] == MESI_M) begin
          remote_m = 1'b1;
          m_owner  = CORE_W'(c);
        end
      end
    end
    case (state)
      ST_IDLE: if (|req_valid) state_n = ST_LOOKUP;
      ST_LOOKUP: begin
        state_n = ST_RESP;
        col_we  = 1'b1;
        case (op_q)
          OP_WRITE: begin
            if (req_st == MESI_M || req_st == MESI_E) begin
              col_next[core_q] = MESI_M;
            end else if (remote_m) begin
              state_n = ST_WRITEBACK;
              col_we  = 1'b0;
              owner_n = m_owner;
            end else begin
              for (int c = 0; c < NUM_CORES; c++) if (remote_v[c]) col_next[c] = MESI_I;
              col_next[core_q] = MESI_M;
              inv_n            = remote_v;
            end
          end
          OP_EVICT: begin
            if (req_st == MESI_M) begin
              state_n = ST_WRITEBACK;
              col_we  = 1'b0;
              owner_n = core_q;
            end else begin
              col_next[core_q] = MESI_I;
            end
          end
          default: begin
            if (req_st != MESI_I) begin
              col_we = 1'b0;
            end else if (remote_m) begin
              state_n = ST_WRITEBACK;
              col_we  = 1'b0;
              owner_n = m_owner;
            end else if (remote_v == '0) begin
              col_next[core_q] = MESI_E;
            end else begin
              // Remote copies are S or a single E here; all settle to S.
              for (int c = 0; c < NUM_CORES; c++) if (remote_v[c]) col_next[c] = MESI_S;
              col_next[core_q] = MESI_S;
            end
          end
        endcase
      end
      ST_WRITEBACK: begin
        if (wb_ready) begin
          state_n = ST_RESP;
          col_we  = 1'b1;
          case (op_q)
            OP_WRITE: begin
              col_next[owner_q] = MESI_I;
              col_next[core_q]  = MESI_M;
              inv_n             = NUM_CORES'(1) << owner_q;
            end
            OP_EVICT: col_next[core_q] = MESI_I;
            default: begin
              col_next[owner_q] = MESI_S;
              col_next[core_q]  = MESI_S;
            end
          endcase
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      core_q      <= '0;
      line_q      <= '0;
      owner_q     <= '0;
      op_q        <= OP_READ;
      snoop_inv_q <= '0;
    end else begin
      state       <= state_n;
      owner_q     <= owner_n;
      snoop_inv_q <= inv_n;
      if (state == ST_IDLE && |req_valid) begin
        core_q <= core_sel;
        line_q <= line_sel;
        op_q   <= (op_sel == 2'b00) ? OP_READ : req_op_t'(op_sel);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CORES; c++)
        for (int l = 0; l < NUM_LINES; l++) dir[c][l] <= MESI_I;
    end else if (col_we) begin
      for (int c = 0; c < NUM_CORES; c++) dir[c][line_q] <= col_next[c];
    end
  end

  assign req_ready  = (state == ST_RESP) ? (NUM_CORES'(1) << core_q) : '0;
  assign resp_state = (state == ST_RESP) ? col_cur[core_q] : MESI_I;
  assign snoop_inv  = snoop_inv_q;
  assign snoop_line = line_q;
  assign wb_valid   = (state == ST_WRITEBACK);
  assign wb_core    = owner_q;
  assign dbg_state  = dir[dbg_core][dbg_line];

endmodule

`default_nettype wire

// File: tb/tb_mesi_snoop_ctrl.sv
// tb_mesi_snoop_ctrl: directed and randomized transactions against a rule-level MESI directory model.
// Revision: 1.0
`default_nettype none

module tb_mesi_snoop_ctrl;

  localparam int NC = 4;
  localparam int NL = 16;
  localparam int I = 0, S = 1, E = 2, M = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [15:0] req_line;
  logic [3:0]  req_ready;
  logic [1:0]  resp_state;
  logic [3:0]  snoop_inv;
  logic [3:0]  snoop_line;
  logic        wb_valid;
  logic [1:0]  wb_core;
  logic        wb_ready;
  logic [1:0]  dbg_core;
  logic [3:0]  dbg_line;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  int mdir [NC][NL];
  int mptr;
  bit pend_valid [NC];
  int pend_op    [NC];
  int pend_line  [NC];

  always #5 clk = ~clk;

  mesi_snoop_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_line   (req_line),
    .req_ready  (req_ready),
    .resp_state (resp_state),
    .snoop_inv  (snoop_inv),
    .snoop_line (snoop_line),
    .wb_valid   (wb_valid),
    .wb_core    (wb_core),
    .wb_ready   (wb_ready),
    .dbg_core   (dbg_core),
    .dbg_line   (dbg_line),
    .dbg_state  (dbg_state)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      req_valid[c]          = pend_valid[c];
      req_op[c*2 +: 2]      = 2'(pend_op[c]);
      req_line[c*4 +: 4]    = 4'(pend_line[c]);
    end
  endtask

  // Entered at a negedge with the DUT idle and requests driven.
  task automatic run_txn(input int k, output int w);
    int ln, op, cur, mown, own, exp_resp;
    bit wb, isread;
    logic [3:0] rv, inv;
    int nxt [NC];
    w = -1;
    for (int i = 0; i < NC; i++) begin
      int c;
      c = (mptr + i) % NC;
      if (w < 0 && pend_valid[c]) w = c;
    end
    if (w < 0) w = 0;
    ln = pend_line[w];
    op = pend_op[w];
    isread = (op == 0 || op == 1);
    cur = mdir[w][ln];
    mown = -1;
    rv = '0;
    for (int c = 0; c < NC; c++) begin
      nxt[c] = mdir[c][ln];
      if (c != w && mdir[c][ln] != I) rv[c] = 1'b1;
      if (c != w && mdir[c][ln] == M) mown = c;
    end
    wb = 1'b0; own = 0; inv = '0;
    if (isread) begin
      if (cur != I) begin
      end else if (mown >= 0) begin
        wb = 1'b1; own = mown; nxt[mown] = S; nxt[w] = S;
      end else if (rv == 0) begin
        nxt[w] = E;
      end else begin
        for (int c = 0; c < NC; c++) if (rv[c]) nxt[c] = S;
        nxt[w] = S;
      end
    end else if (op == 2) begin
      if (cur == M || cur == E) nxt[w] = M;
      else if (mown >= 0) begin
        wb = 1'b1; own = mown; nxt[mown] = I; nxt[w] = M; inv = 4'(1 << mown);
      end else begin
        for (int c = 0; c < NC; c++) if (rv[c]) nxt[c] = I;
        nxt[w] = M; inv = rv;
      end
    end else begin
      if (cur == M) begin wb = 1'b1; own = w; end
      nxt[w] = I;
    end
    exp_resp = nxt[w];

    @(negedge clk);
    check_val("lookup_ready", req_ready, 0);
    check_val("lookup_wb", wb_valid, 0);
    if (wb) begin
      for (int j = 1; j <= k; j++) begin
        @(negedge clk);
        check_val("wb_valid", wb_valid, 1);
        check_val("wb_core", wb_core, own);
        check_val("wb_line", snoop_line, ln);
        check_val("wb_no_ready", req_ready, 0);
        wb_ready = (j == k);
      end
      @(negedge clk);
      wb_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
    check_val("resp_ready", req_ready, 1 << w);
    check_val("resp_state", resp_state, exp_resp);
    check_val("snoop_inv", snoop_inv, inv);
    if (inv != 0) check_val("snoop_line", snoop_line, ln);
    check_val("resp_wb_low", wb_valid, 0);
    for (int c = 0; c < NC; c++) begin
      mdir[c][ln] = nxt[c];
      dbg_core = 2'(c);
      dbg_line = 4'(ln);
      #1;
      check_val("dbg_state", dbg_state, nxt[c]);
    end
    pend_valid[w] = 1'b0;
    drive();
    mptr = (w + 1) % NC;
    @(negedge clk);
    check_val("idle_ready", req_ready, 0);
    check_val("idle_inv", snoop_inv, 0);
  endtask

  task automatic issue(input int core, input int op, input int line, input int k);
    int w;
    pend_valid[core] = 1'b1;
    pend_op[core]    = op;
    pend_line[core]  = line;
    drive();
    run_txn(k, w);
    check_val("issue_winner", w, core);
  endtask

  initial begin
    int w, nz, any;
    rst_n = 1'b0; wb_ready = 1'b0; dbg_core = '0; dbg_line = '0;
    mptr = 0;
    for (int c = 0; c < NC; c++) begin
      pend_valid[c] = 1'b0; pend_op[c] = 1; pend_line[c] = 0;
      for (int l = 0; l < NL; l++) mdir[c][l] = I;
    end
    drive();
    repeat (3) @(negedge clk);
    check_val("rst_ready", req_ready, 0);
    check_val("rst_inv", snoop_inv, 0);
    check_val("rst_wb_valid", wb_valid, 0);
    check_val("rst_resp", resp_state, 0);
    check_val("rst_line", snoop_line, 0);
    check_val("rst_wb_core", wb_core, 0);
    check_val("rst_dbg", dbg_state, I);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 1, 3, 1);
    issue(1, 1, 3, 1);
    issue(1, 1, 5, 1);
    issue(2, 1, 5, 1);
    issue(2, 3, 5, 1);
    issue(0, 2, 5, 1);
    issue(0, 2, 7, 1);
    issue(1, 1, 7, 3);
    issue(2, 2, 1, 1);
    issue(2, 3, 1, 2);
    issue(3, 1, 9, 1);

    for (int c = 0; c < NC; c++) begin
      pend_valid[c] = 1'b1; pend_op[c] = 1; pend_line[c] = 10;
    end
    drive();
    run_txn(1, w);
    check_val("rr_order0", w, 0);
    pend_valid[0] = 1'b1; pend_op[0] = 2; pend_line[0] = 10;
    drive();
    for (int n = 1; n < NC; n++) begin
      run_txn(1, w);
      check_val("rr_order", w, n);
    end
    run_txn(1, w);
    check_val("rr_order_wrap", w, 0);

    for (int it = 0; it < 250; it++) begin
      any = 0;
      for (int c = 0; c < NC; c++) begin
        if (!pend_valid[c] && $urandom_range(0, 2) == 0) begin
          pend_valid[c] = 1'b1;
          pend_op[c]    = $urandom_range(0, 3);
          pend_line[c]  = $urandom_range(0, 3);
        end
        if (pend_valid[c]) any = 1;
      end
      if (any == 0) begin
        pend_valid[it % NC] = 1'b1;
        pend_op[it % NC]    = $urandom_range(0, 3);
        pend_line[it % NC]  = $urandom_range(0, 3);
      end
      drive();
      run_txn($urandom_range(1, 4), w);
    end

    for (int c = 0; c < NC; c++) pend_valid[c] = 1'b0;
    drive();
    @(negedge clk);
    issue(0, 2, 12, 1);
    pend_valid[1] = 1'b1; pend_op[1] = 1; pend_line[1] = 12;
    drive();
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_wb", wb_valid, 1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_wb", wb_valid, 0);
    nz = 0;
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++) begin
        dbg_core = 2'(c);
        dbg_line = 4'(l);
        #0.1;
        if (dbg_state != 2'b00) nz++;
      end
    check_val("rst_dir_clear", nz, 0);
    pend_valid[1] = 1'b0;
    drive();
    nz = 0;
    repeat (2) begin
      @(negedge clk);
      if (req_ready != 0) nz++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (req_ready != 0) nz++;
    end
    check_val("rst_no_ready", nz, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
